// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sclk/mosi/cs in the clk domain, supports all
// four CPOL/CPHA modes, receives MSB-first words and transmits a preloaded word.
module spi_slave #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             sclk,
    input  logic             mosi,
    input  logic             cs,
    output logic             miso,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_load,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_d, cs_d;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   cpol_l, cpha_l;
    logic [WIDTH-1:0]       tx_buf, tx_sr, rx_sr, tx_src;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   lead_edge, trail_edge, sample_edge, shift_edge;
    logic                   cs_fall, cs_rise, last_bit;

    // cs synchroniser resets low so a frame already in progress at reset
    // release never produces a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign cs_fall     = cs_d & ~cs_s;
    assign cs_rise     = ~cs_d & cs_s;
    assign lead_edge   = (sclk_s != cpol_l) && (sclk_d == cpol_l);
    assign trail_edge  = (sclk_s == cpol_l) && (sclk_d != cpol_l);
    assign sample_edge = cpha_l ? trail_edge : lead_edge;
    assign shift_edge  = cpha_l ? lead_edge : trail_edge;
    assign last_bit    = (bit_cnt == CNT_W'(WIDTH - 1));
    assign tx_src      = tx_load ? tx_data : tx_buf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cs_fall) state_next = ACTIVE;
            ACTIVE: begin
                if (cs_rise)                      state_next = IDLE;
                else if (sample_edge && last_bit) state_next = DONE;
            end
            DONE:    state_next = cs_s ? IDLE : ACTIVE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != IDLE);
        rx_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_buf    <= '0;
            tx_sr     <= '0;
            rx_sr     <= '0;
            rx_data   <= '0;
            bit_cnt   <= '0;
            cpol_l    <= 1'b0;
            cpha_l    <= 1'b0;
            miso      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (tx_load) tx_buf <= tx_data;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (cs_fall) begin
                        cpol_l  <= cpol;
                        cpha_l  <= cpha;
                        tx_sr   <= tx_src;
                        rx_sr   <= '0;
                        bit_cnt <= '0;
                        if (!cpha) miso <= tx_src[WIDTH-1];
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        frame_err <= (bit_cnt != '0);
                        miso      <= 1'b0;
                        bit_cnt   <= '0;
                    end else begin
                        if (sample_edge) begin
                            rx_sr <= {rx_sr[WIDTH-2:0], mosi_s};
                            if (last_bit) begin
                                rx_data <= {rx_sr[WIDTH-2:0], mosi_s};
                                bit_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                        // cpha=0: MSB already presented, so the trailing edge
                        // ahead of the first sample of a word is skipped.
                        if (shift_edge) begin
                            if (cpha_l) begin
                                miso  <= tx_sr[WIDTH-1];
                                tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                            end else if (bit_cnt != '0) begin
                                miso  <= tx_sr[WIDTH-2];
                                tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                DONE: begin
                    bit_cnt <= '0;
                    tx_sr   <= tx_src;
                    rx_sr   <= '0;
                    if (cs_s)         miso <= 1'b0;
                    else if (!cpha_l) miso <= tx_src[WIDTH-1];
                end
                default: miso <= 1'b0;
            endcase
        end
    end

endmodule
